// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Brief    : Shared constants and entry type for the instruction-fetch stage.
// Revision : 1.0  initial release
// ============================================================================
package fetch_pkg;

   localparam int unsigned FETCH_ADDR_W = 32;
   localparam int unsigned FETCH_DATA_W = 32;
   localparam int unsigned PC_STEP      = 4;
   localparam logic [FETCH_ADDR_W-1:0] DEF_RESET_PC = 32'h0000_0000;

   typedef struct packed {
      logic [FETCH_ADDR_W-1:0] pc;
      logic [FETCH_DATA_W-1:0] instr;
   } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fetch_fifo
// Brief    : Register-based synchronous FIFO with flush; head read from storage.
// Revision : 1.0  initial release
// ============================================================================
module fetch_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2
) (
   input  logic                         clk,
   input  logic                         i_rst_n,
   input  logic                         i_flush,
   input  logic                         i_push,
   input  logic [WIDTH-1:0]             i_data,
   input  logic                         i_pop,
   output logic [WIDTH-1:0]             o_head,
   output logic [$clog2(DEPTH+1)-1:0]   o_count,
   output logic                         o_empty,
   output logic                         o_full
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W-1:0] r_wr_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_do_push;
   logic             w_do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign o_empty   = (r_count == '0);
   assign o_full    = (r_count == CNT_W'(DEPTH));
   assign o_count   = r_count;
   assign o_head    = r_mem[r_rd_ptr];
   // A push into a full FIFO is allowed when the head leaves in the same cycle.
   assign w_do_pop  = i_pop && !o_empty;
   assign w_do_push = i_push && (!o_full || w_do_pop);

   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (i_flush) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
            r_wr_ptr        <= ptr_inc(r_wr_ptr);
         end
         if (w_do_pop) begin
            r_rd_ptr <= ptr_inc(r_rd_ptr);
         end
         r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
      end
   end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Brief    : Sequential instruction fetch with credit-limited requests,
//            PC tagging, output queue and redirect-driven stale drop.
// Revision : 1.0  initial release
// ============================================================================
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int               ADDR_W   = 32,
   parameter int               DATA_W   = 32,
   parameter int               DEPTH    = 2,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(fetch_pkg::DEF_RESET_PC)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              imem_req_valid,
   input  logic              imem_req_ready,
   output logic [ADDR_W-1:0] imem_req_addr,
   input  logic              imem_rsp_valid,
   input  logic [DATA_W-1:0] imem_rsp_data,
   output logic              if_valid,
   input  logic              if_ready,
   output logic [DATA_W-1:0] if_instr,
   output logic [ADDR_W-1:0] if_pc
);

   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int ENT_W = ADDR_W + DATA_W;

   logic [ADDR_W-1:0] r_fetch_pc;
   logic [CNT_W-1:0]  r_outstanding;
   logic [CNT_W-1:0]  r_drop_cnt;

   logic [CNT_W-1:0]  w_q_cnt;
   logic [CNT_W:0]    w_credit_used;
   logic              w_accept;
   logic              w_rsp_push;
   logic              w_q_empty;
   logic              w_q_full;
   logic              w_if_fire;
   logic [ADDR_W-1:0] w_pend_pc;
   logic [ENT_W-1:0]  w_head;
   logic [CNT_W-1:0]  w_pend_cnt;
   logic              w_pend_empty;
   logic              w_pend_full;
   logic              w_unused_bits;

   // Requests in flight plus queued words may never exceed the queue size,
   // so every response is guaranteed a slot.
   assign w_credit_used  = {1'b0, r_outstanding} + {1'b0, w_q_cnt};
   assign imem_req_valid = reset && !redirect_valid && (w_credit_used < (CNT_W+1)'(DEPTH));
   assign imem_req_addr  = r_fetch_pc;
   assign w_accept       = imem_req_valid && imem_req_ready;
   assign w_rsp_push     = imem_rsp_valid && (r_drop_cnt == '0) && !redirect_valid;

   assign if_valid  = !w_q_empty;
   assign if_pc     = w_head[DATA_W +: ADDR_W];
   assign if_instr  = w_head[DATA_W-1:0];
   assign w_if_fire = if_valid && if_ready;

   assign w_unused_bits = ^{1'b0, redirect_pc[1:0], w_pend_cnt, w_pend_empty, w_pend_full};

   fetch_fifo #(.WIDTH(ADDR_W), .DEPTH(DEPTH)) u_pend_q (
      .clk     (clk),
      .i_rst_n (reset),
      .i_flush (1'b0),
      .i_push  (w_accept),
      .i_data  (r_fetch_pc),
      .i_pop   (imem_rsp_valid),
      .o_head  (w_pend_pc),
      .o_count (w_pend_cnt),
      .o_empty (w_pend_empty),
      .o_full  (w_pend_full)
   );

   fetch_fifo #(.WIDTH(ENT_W), .DEPTH(DEPTH)) u_out_q (
      .clk     (clk),
      .i_rst_n (reset),
      .i_flush (redirect_valid),
      .i_push  (w_rsp_push),
      .i_data  ({w_pend_pc, imem_rsp_data}),
      .i_pop   (w_if_fire),
      .o_head  (w_head),
      .o_count (w_q_cnt),
      .o_empty (w_q_empty),
      .o_full  (w_q_full)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_fetch_pc    <= RESET_PC;
         r_outstanding <= '0;
         r_drop_cnt    <= '0;
      end else begin
         r_outstanding <= r_outstanding + CNT_W'(w_accept) - CNT_W'(imem_rsp_valid);
         if (redirect_valid) begin
            // Requests are suppressed during a redirect, so everything still
            // in flight after this cycle is stale.
            r_fetch_pc <= {redirect_pc[ADDR_W-1:2], 2'b00};
            r_drop_cnt <= r_outstanding - CNT_W'(imem_rsp_valid);
         end else begin
            if (w_accept) begin
               r_fetch_pc <= r_fetch_pc + ADDR_W'(PC_STEP);
            end
            if (imem_rsp_valid && (r_drop_cnt != '0)) begin
               r_drop_cnt <= r_drop_cnt - 1'b1;
            end
         end
      end
   end

   a_rsp_has_space: assert property (@(posedge clk) disable iff (!reset)
      w_rsp_push |-> (!w_q_full || w_if_fire));

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Brief    : Self-checking bench: directed vector table, corner sequences and
//            randomized traffic against a queue-based reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_fetch_unit;
   import fetch_pkg::*;

   localparam int          DEPTH  = 2;
   localparam logic [31:0] RST_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b0;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = '0;
   logic        if_valid;
   logic        if_ready = 1'b0;
   logic [31:0] if_instr;
   logic [31:0] if_pc;

   always #5 clk = ~clk;

   fetch_unit #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
      .clk            (clk),
      .reset          (reset),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .if_valid       (if_valid),
      .if_ready       (if_ready),
      .if_instr       (if_instr),
      .if_pc          (if_pc)
   );

   typedef struct { logic [31:0] pc; logic stale; } flight_t;
   typedef struct { logic [31:0] addr; int due; } mreq_t;
   typedef struct {
      logic        rst;
      logic        irdy;
      logic        exp_rv;
      logic [31:0] exp_addr;
      logic        exp_iv;
      logic [31:0] exp_pc;
   } vec_t;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int lat_lo  = 1;
   int lat_hi  = 1;
   int last_due = 0;

   // Reference model state
   logic [31:0]  m_pc;
   flight_t      m_flight[$];
   fetch_entry_t m_outq[$];
   mreq_t        env_q[$];
   logic [31:0]  delivered[$];
   logic [31:0]  acc_log[$];

   logic        s_rv, s_iv;
   logic [31:0] s_addr, s_pc, s_instr;

   function automatic logic [31:0] memword(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5EED_0000;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_clear();
      m_pc = RST_PC;
      m_flight.delete();
      m_outq.delete();
      env_q.delete();
      delivered.delete();
      acc_log.delete();
      last_due = cyc;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      redirect_valid = 1'b0;
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      if_ready = 1'b0;
      #1;
      chk("rst_if_valid", {31'b0, if_valid}, 32'h0);
      chk("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
      chk("rst_if_pc", if_pc, 32'h0);
      chk("rst_if_instr", if_instr, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      model_clear();
   endtask

   // One clock cycle, entered and left 1 time unit after a rising edge.
   task automatic cycle(input logic irdy, input logic rv, input logic [31:0] rpc,
                        input logic mrdy);
      logic        exp_rv;
      logic        exp_iv;
      flight_t     f;
      mreq_t       mr;
      if_ready       = irdy;
      redirect_valid = rv;
      redirect_pc    = rpc;
      imem_req_ready = mrdy;
      if (env_q.size() > 0 && env_q[0].due <= cyc) begin
         mr = env_q.pop_front();
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = memword(mr.addr);
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = $urandom;
      end
      #1;
      s_rv = imem_req_valid; s_addr = imem_req_addr;
      s_iv = if_valid; s_pc = if_pc; s_instr = if_instr;

      exp_rv = !rv && ((m_flight.size() + m_outq.size()) < DEPTH);
      exp_iv = (m_outq.size() > 0);
      chk("cyc_req_valid", {31'b0, s_rv}, {31'b0, exp_rv});
      if (exp_rv) chk("cyc_req_addr", s_addr, m_pc);
      chk("cyc_if_valid", {31'b0, s_iv}, {31'b0, exp_iv});
      if (exp_iv) begin
         chk("cyc_if_pc", s_pc, m_outq[0].pc);
         chk("cyc_if_instr", s_instr, m_outq[0].instr);
      end

      if (exp_iv && irdy) begin
         delivered.push_back(m_outq[0].pc);
         void'(m_outq.pop_front());
      end
      if (imem_rsp_valid) begin
         if (m_flight.size() == 0) begin
            chk("rsp_without_request", 32'h1, 32'h0);
         end else begin
            f = m_flight.pop_front();
            if (!f.stale && !rv) m_outq.push_back('{pc: f.pc, instr: imem_rsp_data});
         end
      end
      if (s_rv && mrdy) begin
         m_flight.push_back('{pc: m_pc, stale: 1'b0});
         acc_log.push_back(s_addr);
         mr.addr = s_addr;
         mr.due  = cyc + $urandom_range(lat_hi, lat_lo);
         if (mr.due <= last_due) mr.due = last_due + 1;
         last_due = mr.due;
         env_q.push_back(mr);
         m_pc = m_pc + 32'd4;
      end
      if (rv) begin
         m_pc = rpc & 32'hFFFF_FFFC;
         m_outq.delete();
         foreach (m_flight[i]) m_flight[i].stale = 1'b1;
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   function automatic int count_pc(input logic [31:0] pc);
      int n = 0;
      foreach (delivered[i]) if (delivered[i] == pc) n++;
      return n;
   endfunction

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[$];
      logic seen;

      // Streaming with always-ready memory/decode, then backpressure release.
      tbl.push_back('{1, 1, 1, 32'h00, 0, 32'h0});
      tbl.push_back('{0, 1, 1, 32'h04, 0, 32'h0});
      tbl.push_back('{0, 1, 0, 32'h00, 1, 32'h0});
      tbl.push_back('{0, 1, 1, 32'h08, 1, 32'h4});
      tbl.push_back('{0, 1, 1, 32'h0C, 0, 32'h0});
      tbl.push_back('{0, 1, 0, 32'h00, 1, 32'h8});
      tbl.push_back('{0, 1, 1, 32'h10, 1, 32'hC});
      tbl.push_back('{1, 0, 1, 32'h00, 0, 32'h0});
      tbl.push_back('{0, 0, 1, 32'h04, 0, 32'h0});
      tbl.push_back('{0, 0, 0, 32'h00, 1, 32'h0});
      tbl.push_back('{0, 0, 0, 32'h00, 1, 32'h0});
      tbl.push_back('{0, 0, 0, 32'h00, 1, 32'h0});
      tbl.push_back('{0, 1, 0, 32'h00, 1, 32'h0});
      tbl.push_back('{0, 1, 1, 32'h08, 1, 32'h4});
      tbl.push_back('{0, 1, 1, 32'h0C, 0, 32'h0});
      tbl.push_back('{0, 1, 0, 32'h00, 1, 32'h8});

      lat_lo = 1; lat_hi = 1;
      for (int i = 0; i < tbl.size(); i++) begin
         if (tbl[i].rst) do_reset();
         cycle(tbl[i].irdy, 1'b0, 32'h0, 1'b1);
         chk($sformatf("vec%0d_req_valid", i), {31'b0, s_rv}, {31'b0, tbl[i].exp_rv});
         if (tbl[i].exp_rv) chk($sformatf("vec%0d_req_addr", i), s_addr, tbl[i].exp_addr);
         chk($sformatf("vec%0d_if_valid", i), {31'b0, s_iv}, {31'b0, tbl[i].exp_iv});
         if (tbl[i].exp_iv) begin
            chk($sformatf("vec%0d_if_pc", i), s_pc, tbl[i].exp_pc);
            chk($sformatf("vec%0d_if_instr", i), s_instr, memword(tbl[i].exp_pc));
         end
      end

      // Redirect with 0x10 and 0x14 in flight: both dropped, fetch resumes at 0x100.
      do_reset();
      lat_lo = 3; lat_hi = 3;
      cycle(1, 1, 32'h10, 1);
      cycle(1, 0, 0, 1);
      chk("rd_addr_10", s_addr, 32'h10);
      cycle(1, 0, 0, 1);
      chk("rd_addr_14", s_addr, 32'h14);
      cycle(1, 1, 32'h0000_0103, 1);
      cycle(1, 0, 0, 1);
      chk("rd_stall_while_dropping", {31'b0, s_rv}, 32'h0);
      cycle(1, 0, 0, 1);
      chk("rd_next_addr", s_addr, 32'h100);
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         cycle(1, 0, 0, 1);
         seen = s_iv;
      end
      chk("rd_if_seen", {31'b0, seen}, 32'h1);
      chk("rd_first_if_pc", s_pc, 32'h100);

      // Address wrap at the top of the address space.
      do_reset();
      lat_lo = 1; lat_hi = 1;
      cycle(1, 1, 32'hFFFF_FFF8, 1);
      for (int k = 0; k < 10; k++) cycle(1, 0, 0, 1);
      chk("wrap_acc_count", {31'b0, acc_log.size() >= 3}, 32'h1);
      if (acc_log.size() >= 3) begin
         chk("wrap_addr0", acc_log[0], 32'hFFFF_FFF8);
         chk("wrap_addr1", acc_log[1], 32'hFFFF_FFFC);
         chk("wrap_addr2", acc_log[2], 32'h0000_0000);
      end

      // Redirect coinciding with a handshake on 0x20 and a response for 0x24.
      do_reset();
      cycle(1, 1, 32'h20, 1);
      cycle(1, 0, 0, 1);
      cycle(1, 0, 0, 1);
      cycle(1, 1, 32'h80, 1);
      chk("hs_redir_if_valid", {31'b0, s_iv}, 32'h1);
      chk("hs_redir_if_pc", s_pc, 32'h20);
      cycle(1, 0, 0, 1);
      chk("hs_redir_empty_after", {31'b0, s_iv}, 32'h0);
      for (int k = 0; k < 8; k++) cycle(1, 0, 0, 1);
      chk("hs_redir_0x20_once", count_pc(32'h20), 32'd1);
      chk("hs_redir_0x24_never", count_pc(32'h24), 32'd0);
      chk("hs_redir_0x80_seen", count_pc(32'h80), 32'd1);

      // Asynchronous reset with a full output queue.
      do_reset();
      for (int k = 0; k < 4; k++) cycle(0, 0, 0, 1);
      chk("async_pre_if_valid", {31'b0, s_iv}, 32'h1);
      reset = 1'b0;
      #1;
      chk("async_if_valid", {31'b0, if_valid}, 32'h0);
      chk("async_req_valid", {31'b0, imem_req_valid}, 32'h0);
      do_reset();
      cycle(1, 0, 0, 1);
      chk("async_first_req_valid", {31'b0, s_rv}, 32'h1);
      chk("async_first_req_addr", s_addr, RST_PC);

      // Randomized traffic against the reference model.
      do_reset();
      lat_lo = 1; lat_hi = 4;
      for (int k = 0; k < 3000; k++) begin
         logic        rv;
         logic [31:0] rpc;
         rv  = ($urandom % 16) == 0;
         rpc = ($urandom % 2) ? $urandom : (32'hFFFF_FFE0 | ($urandom & 32'h1F));
         cycle(($urandom % 4) != 0, rv, rpc, ($urandom % 3) != 0);
      end
      chk("rand_progress", {31'b0, delivered.size() > 50}, 32'h1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
